// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
// RV32I decode stage with an integrated register file and ID/EX pipeline
// register. It decodes one instruction per cycle, reads operands with an
// optional same-cycle write-back bypass, stalls the front end on a load-use
// hazard and squashes the decode slot on a flush from EX.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_inst/in_pc IF/ID slot contents
//   flush_i                squash the decode slot
//   wb_en/wb_rd/wb_data    register-file write port
//   stall_o                combinational; IF/ID must hold
//   ex_*                   registered ID/EX contents (controls, operands, imm)
//   ex_illegal             the current bubble came from an illegal instruction

module decode_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush_i,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_o,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_ru1,
  output logic [XLEN-1:0] ex_ru2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            ex_AluASrc,
  output logic            ex_AluBSrc,
  output logic            ex_RuWr,
  output logic            ex_DMWr,
  output logic [1:0]      ex_RUDataWrSrc,
  output logic [3:0]      ex_AluOp,
  output logic [4:0]      ex_BrOp,
  output logic [2:0]      ex_DMCtrl,
  output logic            ex_illegal
);

  localparam int IDXW = $clog2(NREGS);
  localparam logic [5:0] NREGS6 = 6'(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [XLEN-1:0] rf [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            knownOp, usesRs1, usesRs2, usesRd, illegal, hazard;
  logic [4:0]      rs1Idx, rs2Idx, rdIdx;
  logic [31:0]     imm32;
  logic [XLEN-1:0] decImm, ru1, ru2;
  logic            decASrc, decBSrc, decRuWr, decDMWr;
  logic [1:0]      decWrSrc;
  logic [3:0]      decAluOp;
  logic [4:0]      decBrOp;
  logic [2:0]      decDMCtrl;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Format decode. Register indices a format does not use are zeroed so
  // that they never take part in hazard checks or illegal-index checks.
  always_comb begin
    knownOp   = 1'b1;
    usesRs1   = 1'b0;
    usesRs2   = 1'b0;
    usesRd    = 1'b0;
    imm32     = '0;
    decASrc   = 1'b0;
    decBSrc   = 1'b1;
    decRuWr   = 1'b0;
    decDMWr   = 1'b0;
    decWrSrc  = 2'b00;
    decAluOp  = 4'b0000;
    decBrOp   = 5'b00000;
    decDMCtrl = 3'b000;
    case (opcode)
      OP_R: begin
        usesRs1 = 1'b1; usesRs2 = 1'b1; usesRd = 1'b1;
        decBSrc = 1'b0; decRuWr = 1'b1;
        decAluOp = {in_inst[30], funct3};
      end
      OP_IALU: begin
        usesRs1 = 1'b1; usesRd = 1'b1; decRuWr = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        // Only the shift-right group carries funct7[5] (srai vs srli).
        decAluOp = {(funct3 == 3'b101) & in_inst[30], funct3};
      end
      OP_LOAD: begin
        usesRs1 = 1'b1; usesRd = 1'b1; decRuWr = 1'b1;
        decWrSrc = 2'b01; decDMCtrl = funct3;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        usesRs1 = 1'b1; usesRs2 = 1'b1; decDMWr = 1'b1; decDMCtrl = funct3;
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        usesRs1 = 1'b1; usesRs2 = 1'b1; decASrc = 1'b1; decBSrc = 1'b0;
        decBrOp = {2'b01, funct3};
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI: begin
        usesRd = 1'b1; decRuWr = 1'b1;
        imm32 = {in_inst[31:12], 12'b0};
      end
      OP_AUIPC: begin
        usesRd = 1'b1; decRuWr = 1'b1; decASrc = 1'b1;
        imm32 = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        usesRd = 1'b1; decRuWr = 1'b1; decASrc = 1'b1;
        decWrSrc = 2'b10; decBrOp = 5'b10000;
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        usesRs1 = 1'b1; usesRd = 1'b1; decRuWr = 1'b1;
        decWrSrc = 2'b10; decBrOp = 5'b10000;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      default: knownOp = 1'b0;
    endcase
  end

  assign rs1Idx = usesRs1 ? in_inst[19:15] : 5'd0;
  assign rs2Idx = usesRs2 ? in_inst[24:20] : 5'd0;
  assign rdIdx  = usesRd  ? in_inst[11:7]  : 5'd0;
  assign decImm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  assign illegal = !knownOp
                 || ({1'b0, rs1Idx} >= NREGS6)
                 || ({1'b0, rs2Idx} >= NREGS6)
                 || ({1'b0, rdIdx}  >= NREGS6);

  // Operand read. x0 and out-of-range indices read 0; a write-back to the
  // same register in this cycle is forwarded when the bypass is enabled.
  always_comb begin
    ru1 = '0;
    ru2 = '0;
    if (rs1Idx != 5'd0 && {1'b0, rs1Idx} < NREGS6) ru1 = rf[rs1Idx[IDXW-1:0]];
    if (rs2Idx != 5'd0 && {1'b0, rs2Idx} < NREGS6) ru2 = rf[rs2Idx[IDXW-1:0]];
    if (RF_BYPASS && wb_en && wb_rd != 5'd0) begin
      if (wb_rd == rs1Idx) ru1 = wb_data;
      if (wb_rd == rs2Idx) ru2 = wb_data;
    end
    if (opcode == OP_LUI) ru1 = '0;
  end

  // Load-use hazard: the load in ID/EX produces a register this instruction
  // reads. A flush wins because the slot is being discarded anyway.
  assign hazard = in_valid && ex_valid && ex_RuWr && (ex_RUDataWrSrc == 2'b01)
               && (ex_rd != 5'd0)
               && ((usesRs1 && rs1Idx == ex_rd) || (usesRs2 && rs2Idx == ex_rd));
  assign stall_o = hazard && !flush_i;

  // Register file; write-back proceeds regardless of stall or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0 && {1'b0, wb_rd} < NREGS6) begin
      rf[wb_rd[IDXW-1:0]] <= wb_data;
    end
  end

  // ID/EX register: everything defaults to a bubble, then the decoded
  // instruction is loaded only when nothing ahead of it in priority fires.
  always_ff @(posedge clk) begin
    ex_valid       <= 1'b0;
    ex_pc          <= '0;
    ex_ru1         <= '0;
    ex_ru2         <= '0;
    ex_imm         <= '0;
    ex_rd          <= '0;
    ex_rs1         <= '0;
    ex_rs2         <= '0;
    ex_AluASrc     <= 1'b0;
    ex_AluBSrc     <= 1'b0;
    ex_RuWr        <= 1'b0;
    ex_DMWr        <= 1'b0;
    ex_RUDataWrSrc <= '0;
    ex_AluOp       <= '0;
    ex_BrOp        <= '0;
    ex_DMCtrl      <= '0;
    ex_illegal     <= 1'b0;
    if (rst_n && !flush_i && !stall_o && in_valid) begin
      if (illegal) begin
        ex_illegal <= 1'b1;
      end else begin
        ex_valid       <= 1'b1;
        ex_pc          <= in_pc;
        ex_ru1         <= ru1;
        ex_ru2         <= ru2;
        ex_imm         <= decImm;
        ex_rd          <= rdIdx;
        ex_rs1         <= rs1Idx;
        ex_rs2         <= rs2Idx;
        ex_AluASrc     <= decASrc;
        ex_AluBSrc     <= decBSrc;
        ex_RuWr        <= decRuWr;
        ex_DMWr        <= decDMWr;
        ex_RUDataWrSrc <= decWrSrc;
        ex_AluOp       <= decAluOp;
        ex_BrOp        <= decBrOp;
        ex_DMCtrl      <= decDMCtrl;
      end
    end
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised RV32I decode stage with an integrated register file and ID/EX pipeline register. It sits between IF/ID and EX. It decodes one instruction per cycle and reads operands with write-back bypass. It detects load-use hazards, stalls the front end, and accepts flushes from EX. Control encodings are unchanged from the existing combinational decode block.

## Interface

Parameters:
- XLEN, 32: datapath width.
- NREGS, 32: architectural registers, 16 or 32. With 16, any rs1/rs2/rd ≥16 is illegal.
- RF_BYPASS, 1: enables the same-cycle WB→decode operand bypass.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush_i  in  1  squash the decode slot (taken branch/jump in EX)
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write address
- wb_data  in  XLEN  write data
- stall_o  out  1  combinational; IF/ID must hold its contents
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_ru1, ex_ru2, ex_imm  out  XLEN  PC, operands, sign-extended immediate
- ex_rd, ex_rs1, ex_rs2  out  5  register indices
- ex_AluASrc, ex_AluBSrc, ex_RuWr, ex_DMWr  out  1  controls
- ex_RUDataWrSrc  out  2  00 ALU, 01 memory, 10 PC+4
- ex_AluOp  out  4  {funct7[5] for R-type and srai, funct3}; 0000 for non-ALU-op formats
- ex_BrOp  out  5  00000 none; {2'b01, funct3} branch; 10000 jal/jalr
- ex_DMCtrl  out  3  funct3 for load/store
- ex_illegal  out  1  registered flag: the bubble came from an unsupported opcode or register index ≥NREGS

## Operation

- **Decoding.** Opcodes: R, I-ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR. Immediates use I/S/B/U/J formats, sign-extended to XLEN.
- **AluASrc.** 1 (PC) for AUIPC, JAL and BRANCH; otherwise 0.
- **AluBSrc.** 1 (imm) for every format except R and BRANCH.
- **LUI.** ru1 is forced to 0.
- **Register file.** NREGS×XLEN. x0 reads 0 and ignores writes. Written on the rising edge when wb_en=1 and wb_rd≠0.
- **Bypass.** When RF_BYPASS=1, wb_en=1, wb_rd≠0 and wb_rd equals rs1 or rs2, wb_data replaces the array value. When RF_BYPASS=0, the read returns the old value.
- **Load-use hazard.** stall_o=1 when all of the following hold:
  - in_valid=1;
  - ID/EX holds ex_valid=1, ex_RuWr=1, ex_RUDataWrSrc=01 and ex_rd≠0;
  - ex_rd matches an rs field the incoming format actually uses.
- **Per-edge priority.** Evaluated in order each edge:
  1. rst_n=0: all ID/EX outputs become 0 and the RF is cleared to 0.
  2. flush_i=1: bubble (all ex_* =0). stall_o is forced to 0.
  3. stall_o=1: bubble. IF/ID holds, so the instruction re-decodes next cycle.
  4. in_valid=0: bubble.
  5. Illegal instruction: bubble with ex_illegal=1.
  6. Otherwise: load the decoded instruction with ex_valid=1.
- **Bubble.** ex_valid=0, ex_RuWr=0, ex_DMWr=0, ex_BrOp=0, all other ex_* =0.
- **Write-back is independent.** The RF write completes during flush, stall or reset-release cycles. During rst_n=0, writes are ignored.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear on ex_* after edge N.
- stall_o is combinational from in_inst, in_valid, flush_i and ID/EX state. It has no dependency on wb_*.
- A load-use stall lasts exactly 1 cycle. After the bubble, ID/EX no longer holds the load, so the dependent instruction issues on the next edge.
- A flush in the same cycle as a hazard produces a bubble with stall_o=0. IF then loads the redirect target.
- Reset values: every output is 0, including stall_o, because ID/EX is empty.
- Reset asserted mid-stream: ID/EX is cleared on the next edge. The instruction in flight is lost.

## Test plan

1. **Reset.** Hold rst_n=0 for 2 cycles, then release with in_valid=0 → ex_valid=0, stall_o=0, all ex_* =0. A read of any register returns 0.
2. **addi.** Write x8=5, then present 0x00540413 (addi x8,x8,5) at pc 0x10 → next cycle: ex_ru1=5, ex_imm=5, ex_rd=8, AluBSrc=1, RuWr=1, AluOp=0000, RUDataWrSrc=00, ex_pc=0x10.
3. **Bypass.** Present 0x008904b3 (add x9,x18,x8) in the same cycle as wb x18=0x87654321 → ex_ru1=0x87654321, ex_ru2=5, AluBSrc=0. With RF_BYPASS=0: ex_ru1=0.
4. **Load-use.** Present 0x00042983 (lw x19,0(x8)), then 0x013909b3 (add x19,x18,x19) → stall_o=1 for one cycle and a bubble enters ID/EX. The add issues on the following edge with ex_rs2=19. Replacing the add with one that does not read x19 gives no stall.
5. **Flush.** Raise flush_i together with the load-use case from scenario 4 → stall_o=0 and a bubble enters ID/EX. Raise flush_i with a valid add → ex_valid=0 and RuWr=0.
6. **Illegal, NREGS=16.** Present 0x013909b3 → ex_valid=0, ex_illegal=1. Present opcode 0x7F → ex_illegal=1. The next legal instruction clears ex_illegal.
